// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for mem_arbiter: requester ownership, FSM states and access size codes.
package mem_arbiter_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// Two-way tie-break for mem_arbiter; gnt[0] = fetch, gnt[1] = data.
// MEM_ARB_ROUND_ROBIN_EN: defined -> round robin on last owner, undefined -> data wins ties.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  owner_e     last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            gnt = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
`else
            gnt = 2'b10;
`endif
        end else begin
            gnt = {d_req, if_req};
        end
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared RAM port, one access in flight.
// Tie policy selected by MEM_ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [1:0]    d_size,
    input  logic          d_signed,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [1:0]    mem_size,
    output logic          mem_signed,
    input  logic [31:0]   mem_rdata
);

    state_e     state_q;
    logic [2:0] cnt_q;
    owner_e     owner_q;
    logic [1:0] pick;
    logic       can_grant;
    logic       rsp;

    // The owner register doubles as the last-granted pointer: both reset to fetch
    // and change only on a grant.
    arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_owner (owner_q),
        .gnt        (pick)
    );

    assign can_grant = (state_q == IDLE) && !rst;
    assign if_gnt    = can_grant && pick[0];
    assign d_gnt     = can_grant && pick[1];

    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_size   = 2'b00;
        mem_signed = 1'b0;
        if (d_gnt) begin
            mem_en     = 1'b1;
            mem_we     = d_we;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
            mem_size   = d_size;
            mem_signed = d_signed;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            mem_size = SIZE_WORD;
        end
    end

    assign rsp       = (state_q == BUSY) && (cnt_q == 3'd1) && !rst;
    assign if_rvalid = rsp && (owner_q == OWN_IF);
    assign d_rvalid  = rsp && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            owner_q <= OWN_IF;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_gnt || d_gnt) begin
                        owner_q <= d_gnt ? OWN_D : OWN_IF;
                        cnt_q   <= 3'(RD_LATENCY);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
